fixed_accumulator_round: RTL and testbench
==========================================

# fixed_accumulator_round

Fixed-point reduction stage placed directly downstream of the signed fixed-point multiplier. It accepts one full-width signed product per handshake and sums `IN_DEPTH` consecutive products into a guarded accumulator. It then rounds, drops `SHIFT` fractional bits and saturates the sum to `OUT_WIDTH`, and presents the result through a single-entry registered output with valid/ready backpressure. Together with the multiplier it forms the dot-product datapath of the linear and matmul layers.

## Interface
- `IN_WIDTH`, 64: signed product width. Equals multiplier `IN_A_WIDTH + IN_B_WIDTH`.
- `IN_DEPTH`, 4: number of products summed per output. Must be ≥ 1.
- `ACC_WIDTH`, `IN_WIDTH + $clog2(IN_DEPTH)`: accumulator width. Guarantees no internal overflow.
- `SHIFT`, 16: fractional bits removed at output. Must satisfy 0 ≤ `SHIFT` < `ACC_WIDTH`.
- `OUT_WIDTH`, 32: signed result width.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset. One clock; reset is asynchronous and active-high.
- `data_in_0` in `IN_WIDTH`: signed product.
- `data_in_0_valid` in 1: upstream holds a valid product.
- `data_in_0_ready` out 1: block accepts `data_in_0` this cycle.
- `data_out_0` out `OUT_WIDTH`: rounded, saturated signed sum.
- `data_out_0_valid` out 1: `data_out_0` holds a valid result.
- `data_out_0_ready` in 1: downstream accepts the result.
- `data_out_0_sat` out 1: current result was clamped. Qualified by `data_out_0_valid`.

## Operation
- Input beat = `data_in_0_valid & data_in_0_ready`. Output beat = `data_out_0_valid & data_out_0_ready`.
- `cnt` (0..`IN_DEPTH`-1) is the only state. It acts as the FSM: `cnt==0` is FIRST, intermediate values are ACCUM, `cnt==IN_DEPTH-1` is LAST.
- On each input beat, `x = sign_extend(data_in_0, ACC_WIDTH)`:
  - FIRST: `acc <= x`.
  - ACCUM: `acc <= acc + x`.
  - In both cases, `cnt <= cnt+1`.
- LAST input beat:
  - `sum = acc + x`; for `IN_DEPTH==1`, `sum = x`.
  - Round half toward +∞: `r = (sum + 2^(SHIFT-1)) >>> SHIFT`. Computed at `ACC_WIDTH+1` bits. When `SHIFT==0`, `r = sum`.
  - Saturate to the signed `OUT_WIDTH` range [−2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)−1].
  - Register `data_out_0 <= clamp(r)`, `data_out_0_sat <= (clamp(r) != r)`, `data_out_0_valid <= 1`, `cnt <= 0`.
- Output register: `data_out_0_valid` clears on an output beat unless a new LAST beat loads it in the same cycle. While valid, `data_out_0` and `data_out_0_sat` hold stable.
- `data_in_0_ready = (cnt != IN_DEPTH-1) | ~data_out_0_valid | data_out_0_ready`. Non-final beats are never stalled by output backpressure.
- `data_in_0_ready` has a combinational path from `data_out_0_ready` only. It has no path from `data_in_0_valid`.
- Reset (async assert, any time, including mid-reduction):
  - `acc=0`, `cnt=0`.
  - `data_out_0=0`, `data_out_0_valid=0`, `data_out_0_sat=0`.
  - Any partial sum is discarded.
  - With `rst` high, `data_in_0_ready` = 1 (`cnt=0`, output empty), but no beat is consumed.

## Timing
- Latency: `data_out_0_valid` rises on the clock edge that accepts the LAST beat, i.e. 1 cycle after the final product is presented.
- Throughput: one product per cycle sustained. One result every `IN_DEPTH` cycles with downstream ready held high.
- Simultaneous output beat and LAST input beat: the new result replaces the old one and valid stays 1, so there is no bubble.
- Output stalled and LAST beat presented: `data_in_0_ready=0`, and `acc` and `cnt` hold until the output drains.
- Outputs are registered except `data_in_0_ready`.

## Test plan
- **Basic sum** (defaults): products 0x10000, 0x20000, 0x30000, 0x40000 on consecutive cycles with ready=1.
  - `data_out_0=10` and `sat=0`, valid for exactly 1 cycle, 1 cycle after the 4th beat.
- **Rounding** (defaults): four products summing to 0x18000 (1.5) → output 2. Sum −0x18000 → −1. Sum 0x17FFF → 1.
- **Saturation** (`OUT_WIDTH=8`, `SHIFT=0`, `IN_DEPTH=2`):
  - 100 + 100 → `data_out_0=127`, `sat=1`.
  - −100 + −100 → −128, `sat=1`.
  - 60 + 60 → 120, `sat=0`.
- **Backpressure**: hold `data_out_0_ready=0` with continuous valid input.
  - Beats 1–3 of the next group are accepted.
  - `data_in_0_ready=0` at beat 4; the first result holds stable.
  - Release ready → the first result is consumed and the second result appears with no data lost.
- **Back-to-back**: 12 products of 0x10000 with ready=1 → three results of 4, on cycles 4, 8 and 12 after start.
- **Mid-operation reset**: assert `rst` asynchronously after 2 of 4 beats.
  - All outputs go to 0 immediately.
  - The next 4 beats of 0x10000 produce 4, not 6.

Source files
------------

// File: rtl/fixed_accumulator_round.sv
// fixed_accumulator_round
//
// Reduction stage behind the signed fixed-point multiplier. Sums IN_DEPTH
// consecutive signed products in a guarded accumulator, then rounds half
// toward +inf, drops SHIFT fractional bits and saturates to OUT_WIDTH.
// The result sits in a single-entry output register.
//
// Handshake: a beat on either side happens on a rising clk edge where valid
// and ready are both high. The sender holds its data stable while valid is
// high and ready is low. Ready never depends on the same side's valid.
//
// Ports:
//   clk, rst            - clock (rising edge), async active-high reset
//   data_in_0           - signed product, IN_WIDTH bits
//   data_in_0_valid     - product on data_in_0 is valid
//   data_in_0_ready     - block accepts a product this cycle
//   data_out_0          - rounded, saturated signed sum, OUT_WIDTH bits
//   data_out_0_valid    - data_out_0 holds a result
//   data_out_0_ready    - downstream accepts the result
//   data_out_0_sat      - the current result was clamped
module fixed_accumulator_round #(
    parameter int IN_WIDTH  = 64,
    parameter int IN_DEPTH  = 4,
    parameter int ACC_WIDTH = IN_WIDTH + $clog2(IN_DEPTH),
    parameter int SHIFT     = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [IN_WIDTH-1:0]  data_in_0,
    input  logic                 data_in_0_valid,
    output logic                 data_in_0_ready,
    output logic [OUT_WIDTH-1:0] data_out_0,
    output logic                 data_out_0_valid,
    input  logic                 data_out_0_ready,
    output logic                 data_out_0_sat
);

    localparam int CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    // One guard bit above the accumulator so adding the rounding constant
    // can never wrap.
    localparam int RW = ACC_WIDTH + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IN_DEPTH - 1);

    // Phase decode of the beat counter. The counter is the only state; the
    // enum names its three regions so checkers can observe them.
    typedef enum logic [1:0] {
        PH_FIRST = 2'd0,
        PH_ACCUM = 2'd1,
        PH_LAST  = 2'd2
    } phase_e;

    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [OUT_WIDTH-1:0]        out_data_q, out_data_d;
    logic                        out_valid_q, out_valid_d;
    logic                        out_sat_q, out_sat_d;

    phase_e                      phase;
    logic                        is_first;
    logic                        is_last;
    logic                        in_beat;
    logic signed [ACC_WIDTH-1:0] x;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [RW-1:0]        sum_ext;
    logic signed [RW-1:0]        rnd;
    logic [RW-OUT_WIDTH:0]       rnd_upper;
    logic                        fits;
    logic [OUT_WIDTH-1:0]        sat_val;

    // With IN_DEPTH==1 the single beat is both FIRST and LAST; LAST wins
    // in the phase decode while is_first still selects the fresh start.
    always_comb begin
        phase = PH_ACCUM;
        if (cnt_q == CNT_LAST) begin
            phase = PH_LAST;
        end else if (cnt_q == '0) begin
            phase = PH_FIRST;
        end
    end

    assign is_first = (cnt_q == '0);
    assign is_last  = (phase == PH_LAST);

    // Only the final beat of a group waits for room in the output register.
    assign data_in_0_ready = ~is_last | ~out_valid_q | data_out_0_ready;
    assign in_beat         = data_in_0_valid & data_in_0_ready;

    assign x       = ACC_WIDTH'($signed(data_in_0));
    assign sum     = is_first ? x : (acc_q + x);
    assign sum_ext = RW'(sum);

    generate
        if (SHIFT == 0) begin : g_no_round
            assign rnd = sum_ext;
        end else begin : g_round
            localparam logic signed [RW-1:0] HALF =
                {{(RW-1){1'b0}}, 1'b1} << (SHIFT - 1);
            assign rnd = (sum_ext + HALF) >>> SHIFT;
        end
    endgenerate

    // The rounded value fits in OUT_WIDTH when every bit from the output
    // sign bit upward is a copy of the sign.
    assign rnd_upper = rnd[RW-1:OUT_WIDTH-1];
    assign fits      = (&rnd_upper) | ~(|rnd_upper);
    assign sat_val   = fits        ? rnd[OUT_WIDTH-1:0] :
                       rnd[RW-1]   ? {1'b1, {(OUT_WIDTH-1){1'b0}}} :
                                     {1'b0, {(OUT_WIDTH-1){1'b1}}};

    always_comb begin
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_valid_d = out_valid_q;

        if (out_valid_q & data_out_0_ready) begin
            out_valid_d = 1'b0;
        end

        if (in_beat) begin
            acc_d = sum;
            if (is_last) begin
                cnt_d       = '0;
                out_data_d  = sat_val;
                out_sat_d   = ~fits;
                // A LAST beat in the same cycle as an output beat refills
                // the register, so valid stays high with no bubble.
                out_valid_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            acc_q       <= '0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign data_out_0       = out_data_q;
    assign data_out_0_valid = out_valid_q;
    assign data_out_0_sat   = out_sat_q;

endmodule

// File: tb/tb_fixed_accumulator_round.sv
// Testbench for fixed_accumulator_round: a default-parameter instance and a
// small instance (IN_WIDTH=16, IN_DEPTH=2, SHIFT=0, OUT_WIDTH=8) for the
// saturation corners. Expected results are queued as stimulus is issued and
// popped by monitors on each output beat.
module tb_fixed_accumulator_round;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Default instance
    logic [63:0] d_in;
    logic        d_valid;
    logic        d_ready;
    logic [31:0] d_out;
    logic        d_out_valid;
    logic        d_out_ready;
    logic        d_sat;

    // Small saturation instance
    logic [15:0] s_in;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_out;
    logic        s_out_valid;
    logic        s_out_ready;
    logic        s_sat;

    fixed_accumulator_round dut (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (d_in),
        .data_in_0_valid  (d_valid),
        .data_in_0_ready  (d_ready),
        .data_out_0       (d_out),
        .data_out_0_valid (d_out_valid),
        .data_out_0_ready (d_out_ready),
        .data_out_0_sat   (d_sat)
    );

    fixed_accumulator_round #(
        .IN_WIDTH  (16),
        .IN_DEPTH  (2),
        .SHIFT     (0),
        .OUT_WIDTH (8)
    ) dut_s (
        .clk              (clk),
        .rst              (rst),
        .data_in_0        (s_in),
        .data_in_0_valid  (s_valid),
        .data_in_0_ready  (s_ready),
        .data_out_0       (s_out),
        .data_out_0_valid (s_out_valid),
        .data_out_0_ready (s_out_ready),
        .data_out_0_sat   (s_sat)
    );

    // Scoreboards: {sat, data}
    logic [32:0] exp_q[$];
    logic [8:0]  exp8_q[$];
    int          out_cyc_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] v, input logic s);
        exp_q.push_back({s, v});
    endtask

    task automatic push_exp8(input logic [7:0] v, input logic s);
        exp8_q.push_back({s, v});
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one product and hold it until accepted (bounded wait).
    task automatic send(input logic [63:0] d);
        int n;
        n = 0;
        d_in = d;
        d_valid = 1'b1;
        @(negedge clk);
        while (!d_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!d_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: ready=%0b after %0d cycles, expected 1", d_ready, n);
        end
        @(posedge clk);
        #1;
        d_valid = 1'b0;
    endtask

    task automatic send8(input logic [15:0] d);
        int n;
        n = 0;
        s_in = d;
        s_valid = 1'b1;
        @(negedge clk);
        while (!s_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!s_ready) begin
            checks++;
            errors++;
            $display("FAIL send8_timeout: ready=%0b after %0d cycles, expected 1", s_ready, n);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    // Monitors: sample away from the active edge; a beat is valid&ready.
    always @(negedge clk) begin : mon_default
        logic [32:0] e;
        if (!rst && d_out_valid && d_out_ready) begin
            checks++;
            out_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got data=%0d sat=%0b, expected no output",
                         $signed(d_out), d_sat);
            end else begin
                e = exp_q.pop_front();
                if ({d_sat, d_out} !== e) begin
                    errors++;
                    $display("FAIL out_data: got data=%0d sat=%0b, expected data=%0d sat=%0b",
                             $signed(d_out), d_sat, $signed(e[31:0]), e[32]);
                end
            end
        end
    end

    always @(negedge clk) begin : mon_small
        logic [8:0] e;
        if (!rst && s_out_valid && s_out_ready) begin
            checks++;
            if (exp8_q.size() == 0) begin
                errors++;
                $display("FAIL out8_unexpected: got data=%0d sat=%0b, expected no output",
                         $signed(s_out), s_sat);
            end else begin
                e = exp8_q.pop_front();
                if ({s_sat, s_out} !== e) begin
                    errors++;
                    $display("FAIL out8_data: got data=%0d sat=%0b, expected data=%0d sat=%0b",
                             $signed(s_out), s_sat, $signed(e[7:0]), e[8]);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int c;
        rst = 1'b1;
        d_in = '0;
        d_valid = 1'b0;
        d_out_ready = 1'b1;
        s_in = '0;
        s_valid = 1'b0;
        s_out_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_data", d_out, 64'd0);
        chk("rst_valid", d_out_valid, 64'd0);
        chk("rst_sat", d_sat, 64'd0);
        chk("rst_ready", d_ready, 64'd1);
        chk("rst_ready8", s_ready, 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);

        // Basic sum: 0xA0000 >> 16 = 10, valid one cycle after 4th beat
        push_exp(32'd10, 1'b0);
        send(64'h10000);
        send(64'h20000);
        send(64'h30000);
        send(64'h40000);
        @(negedge clk);
        chk("basic_valid_rise", d_out_valid, 64'd1);
        @(negedge clk);
        chk("basic_valid_one_cycle", d_out_valid, 64'd0);
        idle(1);

        // Rounding: 1.5 -> 2, -1.5 -> -1, 0x17FFF -> 1, -0.5 -> 0
        push_exp(32'd2, 1'b0);
        send(64'h8000); send(64'h8000); send(64'h8000); send(64'h0);
        push_exp(32'hFFFF_FFFF, 1'b0);
        send(64'hFFFF_FFFF_FFFF_8000); send(64'hFFFF_FFFF_FFFF_8000);
        send(64'hFFFF_FFFF_FFFF_8000); send(64'h0);
        push_exp(32'd1, 1'b0);
        send(64'h7FFF); send(64'h8000); send(64'h8000); send(64'h0);
        push_exp(32'd0, 1'b0);
        send(64'hFFFF_FFFF_FFFF_8000); send(64'h0); send(64'h0); send(64'h0);

        // Full-scale products use the guard bits and clamp at both ends
        push_exp(32'h7FFF_FFFF, 1'b1);
        repeat (4) send(64'h7FFF_FFFF_FFFF_FFFF);
        push_exp(32'h8000_0000, 1'b1);
        repeat (4) send(64'h8000_0000_0000_0000);
        idle(2);

        // Small instance: saturation corners
        push_exp8(8'd127, 1'b1);  send8(16'd100);    send8(16'd100);
        push_exp8(8'h80, 1'b1);   send8(16'hFF9C);   send8(16'hFF9C);
        push_exp8(8'd120, 1'b0);  send8(16'd60);     send8(16'd60);
        push_exp8(8'd127, 1'b0);  send8(16'd127);    send8(16'd0);
        push_exp8(8'd127, 1'b1);  send8(16'd64);     send8(16'd64);
        push_exp8(8'h80, 1'b0);   send8(16'hFFC0);   send8(16'hFFC0);
        idle(2);

        // Back-to-back: results on cycles 4, 8, 12 after start
        out_cyc_q.delete();
        c = cyc;
        repeat (3) push_exp(32'd4, 1'b0);
        repeat (12) send(64'h10000);
        repeat (2) @(negedge clk);
        chk("b2b_count", out_cyc_q.size(), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < out_cyc_q.size())
                chk("b2b_cycle", out_cyc_q[i] - c, 64'(4 * (i + 1)));
        end
        idle(2);

        // Backpressure: first result held, next group stalls at beat 4
        d_out_ready = 1'b0;
        push_exp(32'd4, 1'b0);
        push_exp(32'd8, 1'b0);
        repeat (4) send(64'h10000);
        repeat (3) send(64'h20000);
        d_in = 64'h20000;
        d_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("bp_ready_low", d_ready, 64'd0);
            chk("bp_hold_data", d_out, 64'd4);
            chk("bp_hold_valid", d_out_valid, 64'd1);
        end
        @(posedge clk);
        #1;
        d_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_release", d_ready, 64'd1);
        @(posedge clk);
        #1;
        d_valid = 1'b0;
        @(negedge clk);
        chk("bp_second_valid", d_out_valid, 64'd1);
        idle(2);

        // Mid-operation reset: held result and partial sum both discarded
        d_out_ready = 1'b0;
        repeat (4) send(64'h30000);
        @(negedge clk);
        chk("pre_rst_data", d_out, 64'd12);
        chk("pre_rst_valid", d_out_valid, 64'd1);
        @(posedge clk);
        #1;
        repeat (2) send(64'h10000);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_data", d_out, 64'd0);
        chk("async_rst_valid", d_out_valid, 64'd0);
        chk("async_rst_sat", d_sat, 64'd0);
        chk("async_rst_ready", d_ready, 64'd1);
        d_in = 64'h10000;
        d_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        d_valid = 1'b0;
        d_out_ready = 1'b1;
        chk("rst_no_beat_valid", d_out_valid, 64'd0);
        push_exp(32'd4, 1'b0);
        repeat (4) send(64'h10000);
        idle(3);

        chk("scoreboard_empty", exp_q.size(), 64'd0);
        chk("scoreboard8_empty", exp8_q.size(), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
